plot_scheduler: RTL and testbench
=================================

Name: plot_scheduler

Overview:
- Shares the single VGA pixel-write port between the object engines (ball, paddle, block) that update sprite positions.
- Each requester hands over a rectangle update: previous position, new position, size and colour.
- The block runs one update at a time. It first erases the old rectangle in the background colour, then draws the new rectangle in the object colour, one pixel per clock.
- Arbitration between requesters is round-robin. A req/ack handshake tells the requester when its update is complete.

Parameters:
- NUM_REQ, 3, number of requesters; fixed at 3. Index 0 = ball, 1 = paddle, 2 = block.
- MAX_X, 159, largest visible x coordinate.
- MAX_Y, 119, largest visible y coordinate.
- BG_COLOUR, 3'b000, colour used for the erase pass.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  3  per-requester update request; held high until ack.
- new_x  in  24  {r2,r1,r0} new x, 8 bits each.
- new_y  in  21  {r2,r1,r0} new y, 7 bits each.
- old_x  in  24  {r2,r1,r0} previous x, 8 bits each.
- old_y  in  21  {r2,r1,r0} previous y, 7 bits each.
- size_x  in  24  {r2,r1,r0} width, 8 bits each.
- size_y  in  21  {r2,r1,r0} height, 7 bits each.
- colour  in  9  {r2,r1,r0} draw colour, 3 bits each.
- ack  out  3  one-cycle completion pulse to the granted requester.
- busy  out  1  high in every state except IDLE.
- grant_id  out  2  index of the current or last granted requester.
- vga_x  out  8  pixel x.
- vga_y  out  7  pixel y.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  pixel write enable.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; ack=0, busy=0, grant_id=2 (so the first grant goes to 0), vga_x=0, vga_y=0, vga_colour=0, vga_plot=0.
  - Any pass in progress is abandoned; vga_plot drops immediately, with no clock needed.
- States: IDLE, ERASE, DRAW, DONE.
- IDLE:
  - If any req bit is high, grant round-robin starting from grant_id+1 (mod 3).
  - In the same edge: latch that requester's fields, clear counters cx=cy=0, go to ERASE.
  - If no req is high, stay in IDLE.
- ERASE:
  - Each cycle: vga_x = old_x+cx and vga_y = old_y+cy (truncated to 8/7 bits), vga_colour = BG_COLOUR.
  - Scan is row-major: cx increments; when cx = size_x-1, cx returns to 0 and cy increments.
  - After pixel (size_x-1, size_y-1): clear counters, go to DRAW.
- DRAW: identical scan over new_x/new_y using the latched colour. After the last pixel go to DONE.
- Outputs are registered: a pixel generated in a cycle appears on the vga_* outputs on the following edge.
- Zero size: if size_x=0 or size_y=0 (latched), ERASE and DRAW each last exactly one cycle with vga_plot=0.
- Clipping:
  - A pixel is emitted with vga_plot=1 only if its un-truncated x ≤ MAX_X and y ≤ MAX_Y.
  - A clipped pixel still consumes its cycle, with vga_plot=0.
- DONE:
  - ack[grant_id]=1 for exactly one cycle, then go to IDLE.
  - ack is otherwise 0; no more than one ack bit is ever high.
- Timing for a W×H update (W,H>0) requested in IDLE at edge 0:
  - erase pixels appear on edges 2..W·H+1;
  - draw pixels appear on edges W·H+2..2·W·H+1;
  - ack is high after edge 2·W·H+1, for one cycle.
- Input stability: fields are latched only at grant, so input changes afterwards have no effect.
- Request withdrawal:
  - A req withdrawn before grant is never served.
  - A req dropped after grant does not abort the update.
- Repeat requests: a requester whose req is still high after its ack may be served again, but only after the other pending requesters (round-robin order).
- Widths: the counters cx (8 bits) and cy (7 bits) never exceed size-1. Add in 9/8 bits so that clipping sees the carry.

Test Plan:
- Single update: ball req with old=(50,3), new=(51,4), size 4×4, colour 3'b111.
  - Expect 16 erase pixels at x 50..53, y 3..6, colour 0, row-major.
  - Then 16 draw pixels at x 51..54, y 4..7, colour 7.
  - ack[0] one cycle after the 32nd pixel; busy=1 throughout.
- Round-robin: req=3'b111 held continuously, each size 1×1. Grant order 0,1,2,0; each ack is a single pulse; vga_plot never pulses for a non-granted requester.
- Clipping: paddle new=(150,117), size 20×1. Draw pass emits plot=1 for x 150..159 and plot=0 for the remaining 10 cycles.
- Zero size: size_x=0. Exactly one ERASE cycle and one DRAW cycle with plot=0, then ack in the following cycle.
- Reset mid-operation: assert resetn=0 during DRAW of a 4×4 update. vga_plot=0 and busy=0 without a clock edge. After release, with req still high, the update restarts from ERASE pixel (0,0).
- Late withdrawal: drop req[1] the cycle after grant. The full update still completes and ack[1] is still pulsed.

Source files
------------

// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin owner of the single VGA pixel-write port.
// Each granted update erases the old rectangle in the background colour,
// then draws the new rectangle in the object colour, one pixel per clock.
module plot_scheduler #(
  parameter int         NUM_REQ   = 3,
  parameter int         MAX_X     = 159,
  parameter int         MAX_Y     = 119,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] new_x,
  input  logic [NUM_REQ*7-1:0] new_y,
  input  logic [NUM_REQ*8-1:0] old_x,
  input  logic [NUM_REQ*7-1:0] old_y,
  input  logic [NUM_REQ*8-1:0] size_x,
  input  logic [NUM_REQ*7-1:0] size_y,
  input  logic [NUM_REQ*3-1:0] colour,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 busy,
  output logic [1:0]           grant_id,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot
);

  typedef enum logic [1:0] {S_IDLE, S_ERASE, S_DRAW, S_DONE} state_t;

  state_t     state;
  logic [1:0] pick_id;
  logic [7:0] sel_nx, sel_ox, sel_sx;
  logic [6:0] sel_ny, sel_oy, sel_sy;
  logic [2:0] sel_col;

  // Update latched at grant; the requester may change its inputs afterwards.
  logic [7:0] lat_nx, lat_ox, lat_sx;
  logic [6:0] lat_ny, lat_oy, lat_sy;
  logic [2:0] lat_col;
  logic [7:0] cx;
  logic [6:0] cy;

  // Pixel stage between scan counters and the registered vga_* outputs.
  logic [7:0] p_x;
  logic [6:0] p_y;
  logic [2:0] p_col;
  logic       p_plot;

  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       zero_size, in_range, last_col, last_pix;

  // Round-robin pick: search starts at the requester after the last grant.
  always_comb begin
    case (grant_id)
      2'd0:    pick_id = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd1:    pick_id = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: pick_id = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
    endcase
  end

  // Select the picked requester's fields out of the packed input buses.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    sel_nx  = '0;
    sel_ny  = '0;
    sel_ox  = '0;
    sel_oy  = '0;
    sel_sx  = '0;
    sel_sy  = '0;
    sel_col = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (int'(pick_id) == i) begin
        sel_nx  = new_x[i*8 +: 8];
        sel_ny  = new_y[i*7 +: 7];
        sel_ox  = old_x[i*8 +: 8];
        sel_oy  = old_y[i*7 +: 7];
        sel_sx  = size_x[i*8 +: 8];
        sel_sy  = size_y[i*7 +: 7];
        sel_col = colour[i*3 +: 3];
      end
    end
  end

  // Current pixel address; the extra sum bit keeps the carry for clipping.
  always_comb begin
    base_x    = (state == S_DRAW) ? lat_nx : lat_ox;
    base_y    = (state == S_DRAW) ? lat_ny : lat_oy;
    sum_x     = {1'b0, base_x} + {1'b0, cx};
    sum_y     = {1'b0, base_y} + {1'b0, cy};
    zero_size = (lat_sx == 8'd0) || (lat_sy == 7'd0);
    in_range  = (sum_x <= 9'(MAX_X)) && (sum_y <= 8'(MAX_Y));
    last_col  = (cx == lat_sx - 8'd1);
    last_pix  = zero_size || (last_col && (cy == lat_sy - 7'd1));
  end

  // Scheduler FSM with scan counters, pixel stage and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      grant_id   <= 2'd2;
      ack        <= '0;
      busy       <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      lat_nx     <= '0;
      lat_ny     <= '0;
      lat_ox     <= '0;
      lat_oy     <= '0;
      lat_sx     <= '0;
      lat_sy     <= '0;
      lat_col    <= '0;
      p_x        <= '0;
      p_y        <= '0;
      p_col      <= '0;
      p_plot     <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      ack        <= '0;
      vga_x      <= p_x;
      vga_y      <= p_y;
      vga_colour <= p_col;
      vga_plot   <= p_plot;
      case (state)
        S_IDLE: begin
          p_plot <= 1'b0;
          if (|req) begin
            grant_id <= pick_id;
            lat_nx   <= sel_nx;
            lat_ny   <= sel_ny;
            lat_ox   <= sel_ox;
            lat_oy   <= sel_oy;
            lat_sx   <= sel_sx;
            lat_sy   <= sel_sy;
            lat_col  <= sel_col;
            cx       <= '0;
            cy       <= '0;
            busy     <= 1'b1;
            state    <= S_ERASE;
          end
        end
        S_ERASE, S_DRAW: begin
          p_x    <= sum_x[7:0];
          p_y    <= sum_y[6:0];
          p_col  <= (state == S_DRAW) ? lat_col : BG_COLOUR;
          p_plot <= !zero_size && in_range;
          if (last_pix) begin
            cx    <= '0;
            cy    <= '0;
            state <= (state == S_ERASE) ? S_DRAW : S_DONE;
          end else if (last_col) begin
            cx <= '0;
            cy <= cy + 7'd1;
          end else begin
            cx <= cx + 8'd1;
          end
        end
        S_DONE: begin
          p_plot        <= 1'b0;
          ack[grant_id] <= 1'b1;
          busy          <= 1'b0;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: directed scenarios for plot_scheduler with
// hand-computed pixel streams, ack timing and arbitration order.
module tb_plot_scheduler;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [2:0]  req = '0;
  logic [23:0] new_x = '0, old_x = '0, size_x = '0;
  logic [20:0] new_y = '0, old_y = '0, size_y = '0;
  logic [8:0]  colour = '0;
  logic [2:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;

  int checks = 0;
  int failures = 0;

  plot_scheduler dut (
    .clk(clk), .resetn(resetn), .req(req),
    .new_x(new_x), .new_y(new_y), .old_x(old_x), .old_y(old_y),
    .size_x(size_x), .size_y(size_y), .colour(colour),
    .ack(ack), .busy(busy), .grant_id(grant_id),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fields(input int r, input int ox, input int oy, input int nx,
                            input int ny, input int sx, input int sy, input int col);
    old_x[r*8 +: 8]  = 8'(ox);
    old_y[r*7 +: 7]  = 7'(oy);
    new_x[r*8 +: 8]  = 8'(nx);
    new_y[r*7 +: 7]  = 7'(ny);
    size_x[r*8 +: 8] = 8'(sx);
    size_y[r*7 +: 7] = 7'(sy);
    colour[r*3 +: 3] = 3'(col);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    checks++;
    if ({ack, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot} !==
        {3'b000, 1'b0, 2'd2, 8'd0, 7'd0, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: ack=%b busy=%b grant=%0d x=%0d y=%0d c=%0d plot=%b",
               ack, busy, grant_id, vga_x, vga_y, vga_colour, vga_plot);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_single();
    logic [18:0] exp;
    set_fields(0, 50, 3, 51, 4, 4, 4, 7);
    req = 3'b001;
    step();  // edge 0: grant
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k <= 32) begin
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL single_busy edge %0d: busy=%b expected 1", k, busy);
        end
      end
      if (k == 1) exp = '0;
      else if (k <= 17) exp = {1'b1, 8'(50 + (k-2)%4), 7'(3 + (k-2)/4), 3'd0};
      else exp = {1'b1, 8'(51 + (k-18)%4), 7'(4 + (k-18)/4), 3'd7};
      checks++;
      if (k == 1) begin
        if (vga_plot !== 1'b0) begin
          failures++;
          $display("FAIL single_lead edge 1: plot=%b expected 0", vga_plot);
        end
      end else if ({vga_plot, vga_x, vga_y, vga_colour} !== exp) begin
        failures++;
        $display("FAIL single_pixel edge %0d: plot=%b x=%0d y=%0d c=%0d expected plot=%b x=%0d y=%0d c=%0d",
                 k, vga_plot, vga_x, vga_y, vga_colour, exp[18], exp[17:10], exp[9:3], exp[2:0]);
      end
      checks++;
      if (ack !== ((k == 33) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL single_ack edge %0d: ack=%b", k, ack);
      end
    end
    req = 3'b000;
    step();
    step();
    checks++;
    if ({ack, busy} !== 4'b0000) begin
      failures++;
      $display("FAIL single_after: ack=%b busy=%b expected 000 0", ack, busy);
    end
  endtask

  task automatic test_round_robin();
    int order [4] = '{0, 1, 2, 0};
    int ox [3] = '{10, 20, 30};
    int nx [3] = '{11, 21, 31};
    int cl [3] = '{1, 2, 4};
    int n = 0;
    int phase = 0;
    int r;
    logic [2:0] prev_ack = '0;
    logic [19:0] exp;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) set_fields(i, ox[i], ox[i], nx[i], ox[i], 1, 1, cl[i]);
    req = 3'b111;
    for (int k = 0; k < 40 && n < 4; k++) begin
      step();
      r = order[n];
      if (vga_plot) begin
        if (phase == 0) exp = {2'(r), 8'(ox[r]), 7'(ox[r]), 3'd0};
        else exp = {2'(r), 8'(nx[r]), 7'(ox[r]), 3'(cl[r])};
        checks++;
        if ({grant_id, vga_x, vga_y, vga_colour} !== exp) begin
          failures++;
          $display("FAIL rr_pixel grant#%0d: grant=%0d x=%0d y=%0d c=%0d expected grant=%0d x=%0d y=%0d c=%0d",
                   n, grant_id, vga_x, vga_y, vga_colour, exp[19:18], exp[17:10], exp[9:3], exp[2:0]);
        end
        phase++;
      end
      if (ack != 3'b000) begin
        checks++;
        if (ack !== 3'(1 << r) || prev_ack !== 3'b000 || phase != 2) begin
          failures++;
          $display("FAIL rr_ack grant#%0d: ack=%b prev=%b pixels=%0d expected ack=%b after 2 pixels",
                   n, ack, prev_ack, phase, 3'(1 << r));
        end
        n++;
        phase = 0;
        if (n == 4) req = 3'b000;
      end
      prev_ack = ack;
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL rr_timeout: acks=%0d expected 4", n);
    end
    step();
    checks++;
    if (ack !== 3'b000) begin
      failures++;
      $display("FAIL rr_ack_width: ack=%b expected 000", ack);
    end
  endtask

  task automatic test_clipping();
    int x;
    // Right-edge clip: erase 148..167 at y=119, draw 150..169 at y=117.
    set_fields(1, 148, 119, 150, 117, 20, 1, 6);
    req = 3'b010;
    step();
    for (int k = 1; k <= 41; k++) begin
      step();
      if (k >= 2) begin
        x = (k <= 21) ? 148 + (k - 2) : 150 + (k - 22);
        checks++;
        if (vga_plot !== (x <= 159) || (vga_plot && vga_x !== 8'(x))) begin
          failures++;
          $display("FAIL clip_x edge %0d: plot=%b x=%0d expected plot=%b x=%0d",
                   k, vga_plot, vga_x, (x <= 159), x);
        end
      end
      if (k == 41) begin
        checks++;
        if (ack !== 3'b010) begin
          failures++;
          $display("FAIL clip_ack: ack=%b expected 010", ack);
        end
      end
    end
    req = 3'b000;
    step();
    // Carry cases: x sums past 255 and y sums past 127 must stay clipped.
    set_fields(2, 254, 118, 10, 127, 4, 2, 5);
    req = 3'b100;
    step();
    for (int k = 1; k <= 17; k++) begin
      step();
      checks++;
      if (vga_plot !== 1'b0) begin
        failures++;
        $display("FAIL clip_carry edge %0d: plot=%b x=%0d y=%0d expected plot=0",
                 k, vga_plot, vga_x, vga_y);
      end
    end
    checks++;
    if (ack !== 3'b100) begin
      failures++;
      $display("FAIL clip_carry_ack: ack=%b expected 100", ack);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_zero_size();
    set_fields(0, 5, 5, 6, 6, 0, 3, 2);
    req = 3'b001;
    step();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (vga_plot !== 1'b0 || busy !== (k <= 2) || ack !== ((k == 3) ? 3'b001 : 3'b000)) begin
        failures++;
        $display("FAIL zero_size edge %0d: plot=%b busy=%b ack=%b expected plot=0 busy=%b ack=%b",
                 k, vga_plot, busy, ack, (k <= 2), ((k == 3) ? 3'b001 : 3'b000));
      end
      if (k == 3) req = 3'b000;
    end
  endtask

  task automatic test_reset_mid();
    set_fields(0, 5, 5, 6, 6, 4, 4, 3);
    req = 3'b001;
    step();
    for (int k = 1; k <= 20; k++) step();
    checks++;
    if ({vga_plot, vga_colour} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL mid_draw: plot=%b c=%0d expected plot=1 c=3", vga_plot, vga_colour);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({vga_plot, busy, ack, grant_id} !== {1'b0, 1'b0, 3'b000, 2'd2}) begin
      failures++;
      $display("FAIL async_reset: plot=%b busy=%b ack=%b grant=%0d expected 0 0 000 2",
               vga_plot, busy, ack, grant_id);
    end
    #1;
    resetn = 1'b1;
    step();  // edge 0: regrant with req still high
    for (int k = 1; k <= 33; k++) begin
      step();
      if (k == 2) begin
        checks++;
        if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd5, 7'd5, 3'd0}) begin
          failures++;
          $display("FAIL restart_pixel: plot=%b x=%0d y=%0d c=%0d expected 1 5 5 0",
                   vga_plot, vga_x, vga_y, vga_colour);
        end
      end
    end
    checks++;
    if (ack !== 3'b001) begin
      failures++;
      $display("FAIL restart_ack: ack=%b expected 001", ack);
    end
    req = 3'b000;
    step();
  endtask

  task automatic test_late_withdraw();
    set_fields(1, 40, 40, 42, 41, 2, 2, 6);
    set_fields(2, 70, 70, 71, 71, 1, 1, 1);
    req = 3'b010;
    step();       // edge 0: grant to requester 1
    req = 3'b000; // dropped the cycle after grant
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 3) req = 3'b100;  // brief request withdrawn before any grant
      if (k == 4) req = 3'b000;
      if (k == 6) begin
        checks++;
        if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'd42, 7'd41, 3'd6}) begin
          failures++;
          $display("FAIL late_draw: plot=%b x=%0d y=%0d c=%0d expected 1 42 41 6",
                   vga_plot, vga_x, vga_y, vga_colour);
        end
      end
    end
    checks++;
    if (ack !== 3'b010) begin
      failures++;
      $display("FAIL late_ack: ack=%b expected 010", ack);
    end
    step();
    step();
    step();
    checks++;
    if ({busy, grant_id} !== {1'b0, 2'd1}) begin
      failures++;
      $display("FAIL withdrawn_served: busy=%b grant=%0d expected 0 1", busy, grant_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_clipping();
    test_zero_size();
    test_reset_mid();
    test_late_withdraw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
